// File: rtl/fwd_source_pipe_pkg.sv
// Shared types for the forwarding source pipe: widths, memory-sequencer states
// and the EX/MEM and MEM/WB latch layouts.
package fwd_source_pipe_pkg;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   typedef enum logic [1:0] {
      M_IDLE = 2'd0,
      M_WAIT = 2'd1,
      M_DONE = 2'd2
   } mem_state_t;

   typedef struct packed {
      regbits_t sel;
      logic     wen;
      logic     memread;
      logic     memwrite;
      word_t    data;
   } em_latch_t;

   typedef struct packed {
      regbits_t sel;
      logic     wen;
      word_t    data;
   } mw_latch_t;

   localparam em_latch_t EM_BUBBLE = '0;
   localparam mw_latch_t MW_BUBBLE = '0;

   // Register $0 is hardwired, so a write to it is never forwardable.
   function automatic logic wen_gate(input regbits_t sel, input logic wen);
      return wen & (sel != '0);
   endfunction

endpackage

// File: rtl/fwd_source_pipe_if.sv
// Pipeline-side bundle of the forwarding source: EX/decode/memory inputs and the
// latched EX/MEM, MEM/WB forwarding outputs.
interface fwd_source_pipe_if;
   import fwd_source_pipe_pkg::*;

   logic     ihit;
   logic     dhit;
   logic     ex_flush;
   regbits_t ex_wsel;
   logic     ex_wen;
   logic     ex_memread;
   logic     ex_memwrite;
   word_t    ex_result;
   word_t    dmemload;
   regbits_t de_rs;
   regbits_t de_rt;

   regbits_t emsel;
   logic     emwen;
   word_t    emdata;
   logic     em_memread;
   logic     em_memwrite;
   regbits_t mwsel;
   logic     mwwen;
   word_t    mwdata;
   logic     mem_busy;
   logic     load_use;

   modport master (
      output ihit, dhit, ex_flush, ex_wsel, ex_wen, ex_memread, ex_memwrite,
             ex_result, dmemload, de_rs, de_rt,
      input  emsel, emwen, emdata, em_memread, em_memwrite, mwsel, mwwen,
             mwdata, mem_busy, load_use
   );

   modport slave (
      input  ihit, dhit, ex_flush, ex_wsel, ex_wen, ex_memread, ex_memwrite,
             ex_result, dmemload, de_rs, de_rt,
      output emsel, emwen, emdata, em_memread, em_memwrite, mwsel, mwwen,
             mwdata, mem_busy, load_use
   );

endinterface

// File: rtl/fwd_source_pipe_mem_seq.sv
// Data-memory wait sequencer: holds the pipe while a mem op is outstanding and
// captures load data that returns before the fetch side is ready.
//
//  state  | meaning
//  M_IDLE | no captured data; a mem op in EX/MEM without dhit stalls here
//  M_WAIT | mem op outstanding, waiting for dhit
//  M_DONE | dhit seen but ihit not yet; load data frozen in hold register
module fwd_source_pipe_mem_seq
   import fwd_source_pipe_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  ihit,
   input  logic  dhit,
   input  logic  mem_op,
   input  word_t dmemload,
   output logic  mem_busy,
   output word_t load_data
);

   mem_state_t state_q, state_d;
   word_t      hold_q;
   logic       hold_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= M_IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         if (hold_en) hold_q <= dmemload;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_en = 1'b0;
      unique case (state_q)
         M_IDLE: begin
            if (mem_op && !dhit) begin
               state_d = M_WAIT;
            end else if (dhit && !ihit) begin
               state_d = M_DONE;
               hold_en = 1'b1;
            end
         end
         M_WAIT: begin
            if (dhit) begin
               if (ihit) begin
                  state_d = M_IDLE;
               end else begin
                  state_d = M_DONE;
                  hold_en = 1'b1;
               end
            end
         end
         M_DONE: begin
            if (ihit) state_d = M_IDLE;
         end
         default: state_d = M_IDLE;
      endcase
   end

   assign mem_busy  = mem_op & ~(dhit | (state_q == M_DONE));
   assign load_data = (state_q == M_DONE) ? hold_q : dmemload;

endmodule

// File: rtl/fwd_source_pipe.sv
// Producer side of the forwarding path: EX/MEM and MEM/WB destination latches,
// memory-wait sequencing and load-use detection.
module fwd_source_pipe
   import fwd_source_pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   fwd_source_pipe_if.slave  pipe
);

   em_latch_t em_q, em_d;
   mw_latch_t mw_q, mw_d;
   logic      mem_busy;
   logic      advance;
   logic      em_wen_eff;
   word_t     load_data;

   fwd_source_pipe_mem_seq u_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .ihit      (pipe.ihit),
      .dhit      (pipe.dhit),
      .mem_op    (em_q.memread | em_q.memwrite),
      .dmemload  (pipe.dmemload),
      .mem_busy  (mem_busy),
      .load_data (load_data)
   );

   assign advance    = pipe.ihit & ~mem_busy;
   assign em_wen_eff = wen_gate(em_q.sel, em_q.wen);

   always_comb begin
      em_d = em_q;
      mw_d = mw_q;
      if (advance) begin
         if (pipe.ex_flush) begin
            em_d = EM_BUBBLE;
         end else begin
            em_d.sel      = pipe.ex_wsel;
            em_d.wen      = pipe.ex_wen;
            em_d.memread  = pipe.ex_memread;
            em_d.memwrite = pipe.ex_memwrite;
            em_d.data     = pipe.ex_result;
         end
         mw_d.sel  = em_q.sel;
         mw_d.wen  = em_wen_eff & ~em_q.memwrite;
         mw_d.data = em_q.memread ? load_data : em_q.data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         em_q <= EM_BUBBLE;
         mw_q <= MW_BUBBLE;
      end else begin
         em_q <= em_d;
         mw_q <= mw_d;
      end
   end

   assign pipe.emsel       = em_q.sel;
   assign pipe.emwen       = em_wen_eff;
   assign pipe.emdata      = em_q.data;
   assign pipe.em_memread  = em_q.memread;
   assign pipe.em_memwrite = em_q.memwrite;
   assign pipe.mwsel       = mw_q.sel;
   assign pipe.mwwen       = wen_gate(mw_q.sel, mw_q.wen);
   assign pipe.mwdata      = mw_q.data;
   assign pipe.mem_busy    = mem_busy;
   // Only registered state feeds the compare so the hazard path stays short.
   assign pipe.load_use    = em_q.memread & em_wen_eff &
                             ((em_q.sel == pipe.de_rs) | (em_q.sel == pipe.de_rt));

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Bench for fwd_source_pipe: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_fwd_source_pipe;
   import fwd_source_pipe_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fwd_source_pipe_if bus ();

   fwd_source_pipe dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pipe  (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model: contents of each stage plus "memory already answered" flag/value.
   regbits_t m_em_sel, m_mw_sel;
   logic     m_em_wen, m_em_rd, m_em_wr, m_mw_wen, m_got;
   word_t    m_em_data, m_mw_data, m_gval;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   task automatic model_reset();
      m_em_sel = '0; m_em_wen = 1'b0; m_em_rd = 1'b0; m_em_wr = 1'b0; m_em_data = '0;
      m_mw_sel = '0; m_mw_wen = 1'b0; m_mw_data = '0;
      m_got = 1'b0; m_gval = '0;
   endtask

   function automatic logic m_emwen();
      return m_em_wen && (m_em_sel != 5'd0);
   endfunction

   function automatic logic m_busy();
      return (m_em_rd || m_em_wr) && !(bus.dhit || m_got);
   endfunction

   task automatic compare_all();
      logic lu;
      lu = m_em_rd && m_emwen() && (m_em_sel == bus.de_rs || m_em_sel == bus.de_rt);
      chk("emsel",       32'(bus.emsel),       32'(m_em_sel));
      chk("emwen",       32'(bus.emwen),       32'(m_emwen()));
      chk("emdata",      bus.emdata,           m_em_data);
      chk("em_memread",  32'(bus.em_memread),  32'(m_em_rd));
      chk("em_memwrite", 32'(bus.em_memwrite), 32'(m_em_wr));
      chk("mwsel",       32'(bus.mwsel),       32'(m_mw_sel));
      chk("mwwen",       32'(bus.mwwen),       32'(m_mw_wen));
      chk("mwdata",      bus.mwdata,           m_mw_data);
      chk("mem_busy",    32'(bus.mem_busy),    32'(m_busy()));
      chk("load_use",    32'(bus.load_use),    32'(lu));
   endtask

   // Inputs must be set (at the falling edge); checks, advances one clock, returns at next falling edge.
   task automatic tick();
      regbits_t n_em_sel, n_mw_sel;
      logic     n_em_wen, n_em_rd, n_em_wr, n_mw_wen, n_got, adv;
      word_t    n_em_data, n_mw_data, n_gval;
      #1;
      compare_all();
      n_em_sel = m_em_sel; n_em_wen = m_em_wen; n_em_rd = m_em_rd; n_em_wr = m_em_wr;
      n_em_data = m_em_data; n_mw_sel = m_mw_sel; n_mw_wen = m_mw_wen; n_mw_data = m_mw_data;
      n_got = m_got; n_gval = m_gval;
      adv = bus.ihit && !m_busy();
      if (adv) begin
         n_mw_sel  = m_em_sel;
         n_mw_wen  = m_emwen() && !m_em_wr;
         n_mw_data = m_em_rd ? (m_got ? m_gval : bus.dmemload) : m_em_data;
         if (bus.ex_flush) begin
            n_em_sel = '0; n_em_wen = 1'b0; n_em_rd = 1'b0; n_em_wr = 1'b0; n_em_data = '0;
         end else begin
            n_em_sel = bus.ex_wsel; n_em_wen = bus.ex_wen; n_em_rd = bus.ex_memread;
            n_em_wr = bus.ex_memwrite; n_em_data = bus.ex_result;
         end
         n_got = 1'b0;
      end else if (bus.dhit && !bus.ihit && !m_got) begin
         n_got  = 1'b1;
         n_gval = bus.dmemload;
      end
      @(posedge clk);
      m_em_sel = n_em_sel; m_em_wen = n_em_wen; m_em_rd = n_em_rd; m_em_wr = n_em_wr;
      m_em_data = n_em_data; m_mw_sel = n_mw_sel; m_mw_wen = n_mw_wen; m_mw_data = n_mw_data;
      m_got = n_got; m_gval = n_gval;
      @(negedge clk);
   endtask

   task automatic set_ex(input regbits_t sel, input logic wen, input logic rd,
                         input logic wr, input word_t res);
      bus.ex_wsel = sel; bus.ex_wen = wen; bus.ex_memread = rd;
      bus.ex_memwrite = wr; bus.ex_result = res; bus.ex_flush = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      set_ex(5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      bus.ihit = 1'b0; bus.dhit = 1'b0; bus.dmemload = '0;
      bus.de_rs = '0; bus.de_rt = '0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("reset_emsel",    32'(bus.emsel),    32'd0);
      chk("reset_mwdata",   bus.mwdata,        32'd0);
      chk("reset_mem_busy", 32'(bus.mem_busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // ALU chain
      set_ex(5'd5, 1'b1, 1'b0, 1'b0, 32'h1234); bus.ihit = 1'b1;
      tick();
      chk("alu_emsel",  32'(bus.emsel), 32'd5);
      chk("alu_emwen",  32'(bus.emwen), 32'd1);
      chk("alu_emdata", bus.emdata,     32'h1234);
      set_ex(5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      chk("alu_mwsel",  32'(bus.mwsel), 32'd5);
      chk("alu_mwwen",  32'(bus.mwwen), 32'd1);
      chk("alu_mwdata", bus.mwdata,     32'h1234);

      // Register 0 is never forwardable
      set_ex(5'd0, 1'b1, 1'b0, 1'b0, 32'h77);
      tick();
      chk("reg0_emwen", 32'(bus.emwen), 32'd0);
      set_ex(5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      chk("reg0_mwwen", 32'(bus.mwwen), 32'd0);

      // Load to $8 with three cycles of memory wait
      set_ex(5'd8, 1'b1, 1'b1, 1'b0, 32'h100); bus.dhit = 1'b0;
      tick();
      set_ex(5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("wait_busy", 32'(bus.mem_busy), 32'd1);
         tick();
         chk("wait_emsel_frozen", 32'(bus.emsel), 32'd8);
      end
      bus.dhit = 1'b1; bus.dmemload = 32'hCAFEF00D;
      #1;
      chk("wait_busy_release", 32'(bus.mem_busy), 32'd0);
      tick();
      chk("load_mwsel",  32'(bus.mwsel), 32'd8);
      chk("load_mwwen",  32'(bus.mwwen), 32'd1);
      chk("load_mwdata", bus.mwdata,     32'hCAFEF00D);

      // dhit arrives before ihit: held data wins over later bus value
      bus.dhit = 1'b0;
      set_ex(5'd10, 1'b1, 1'b1, 1'b0, 32'd0);
      tick();
      set_ex(5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      bus.ihit = 1'b0; bus.dhit = 1'b1; bus.dmemload = 32'hAA;
      tick();
      bus.dhit = 1'b0; bus.dmemload = 32'h55; bus.ihit = 1'b1;
      tick();
      chk("early_mwsel",  32'(bus.mwsel), 32'd10);
      chk("early_mwdata", bus.mwdata,     32'hAA);

      // Load-use against decode operands
      set_ex(5'd9, 1'b1, 1'b1, 1'b0, 32'd0);
      tick();
      set_ex(5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      bus.ihit = 1'b0; bus.de_rs = 5'd0; bus.de_rt = 5'd9;
      #1;
      chk("load_use_hit", 32'(bus.load_use), 32'd1);
      tick();
      bus.de_rs = 5'd3; bus.de_rt = 5'd3;
      #1;
      chk("load_use_miss", 32'(bus.load_use), 32'd0);
      tick();
      bus.dhit = 1'b1; bus.ihit = 1'b1;
      tick();
      bus.dhit = 1'b0;

      // Flush on advance, then flush while stalled has no effect
      set_ex(5'd7, 1'b1, 1'b0, 1'b0, 32'h99); bus.ex_flush = 1'b1;
      tick();
      chk("flush_emwen", 32'(bus.emwen), 32'd0);
      chk("flush_emsel", 32'(bus.emsel), 32'd0);
      set_ex(5'd6, 1'b1, 1'b0, 1'b0, 32'h5);
      tick();
      bus.ex_flush = 1'b1; bus.ihit = 1'b0;
      tick();
      chk("stall_flush_emsel", 32'(bus.emsel), 32'd6);
      chk("stall_flush_emwen", 32'(bus.emwen), 32'd1);
      bus.ex_flush = 1'b0; bus.ihit = 1'b1;

      // Async reset while waiting on memory
      set_ex(5'd11, 1'b1, 1'b1, 1'b0, 32'd0);
      tick();
      set_ex(5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_emsel",    32'(bus.emsel),       32'd0);
      chk("rst_em_rd",    32'(bus.em_memread),  32'd0);
      chk("rst_mwsel",    32'(bus.mwsel),       32'd0);
      chk("rst_mwdata",   bus.mwdata,           32'd0);
      chk("rst_mem_busy", 32'(bus.mem_busy),    32'd0);
      chk("rst_state",    32'(dut.u_seq.state_q), 32'(M_IDLE));
      model_reset();
      #2;
      rst_n = 1'b1;
      @(negedge clk);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         int kind;
         kind = int'($urandom_range(0, 7));
         bus.ihit       = ($urandom_range(0, 3) != 0);
         bus.dhit       = ($urandom_range(0, 1) != 0);
         bus.ex_flush   = ($urandom_range(0, 9) == 0);
         bus.ex_wsel    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 10));
         bus.ex_wen     = ($urandom_range(0, 3) != 0);
         bus.ex_memread = (kind < 2);
         bus.ex_memwrite = (kind == 2 || kind == 3);
         bus.ex_result  = $urandom();
         bus.dmemload   = $urandom();
         bus.de_rs      = 5'($urandom_range(0, 10));
         bus.de_rt      = 5'($urandom_range(0, 10));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
